// File: rtl/mod_n_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_chk_pkg
// Description : Shared types, defaults and next-count rule for the mod-N
//               counter checker.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_n_chk_pkg;

    localparam int unsigned c_default_width = 4;
    localparam int unsigned c_default_mod_n = 10;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } chk_state_e;

    // Ordered rule: DUT reset, then load (raw value, even if illegal), then wrap, then increment.
    function automatic int unsigned next_count(
        input int unsigned count,
        input logic        load,
        input int unsigned load_data,
        input logic        dut_reset_n,
        input int unsigned mod_n
    );
        if (!dut_reset_n)
            return 0;
        else if (load)
            return load_data;
        else if (count >= mod_n - 1)
            return 0;
        else
            return count + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] value
);

    localparam logic [ERR_W-1:0] c_max = '1;

    logic [ERR_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (clr)
            r_value <= '0;
        else if (inc && (r_value != c_max))
            r_value <= r_value + 1'b1;
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/mod_n_count_checker.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_count_checker
// Description : Passive monitor predicting a loadable mod-N counter's next
//               count; flags divergence and keeps error statistics.
//               Define CHECKER_STICKY_FAULT_EN to latch FAULT on first error.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_count_checker
    import mod_n_chk_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width,
    parameter int unsigned MOD_N = c_default_mod_n,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             illegal_load,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_err
);

    chk_state_e       r_state;
    logic [WIDTH-1:0] r_expected;
    logic             r_mismatch;
    logic             r_illegal;
    logic [WIDTH-1:0] r_first_err;

    logic             w_compare_en;
    logic [WIDTH-1:0] w_reference;
    logic             w_mismatch;
    logic             w_resync;
    logic             w_illegal;
    logic [WIDTH-1:0] w_next;
    logic [ERR_W-1:0] w_err_count;

    assign w_compare_en = (r_state == TRACK);
    // A sampled DUT reset means the counter must already read zero.
    assign w_reference  = dut_reset_n ? r_expected : '0;
    assign w_mismatch   = w_compare_en && (count != w_reference);
    assign w_resync     = !dut_reset_n || load;
    assign w_illegal    = load && dut_reset_n && (32'(load_data) >= MOD_N);
    assign w_next       = WIDTH'(next_count(32'(count), load, 32'(load_data),
                                            dut_reset_n, MOD_N));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= UNLOCK;
            r_expected  <= '0;
            r_mismatch  <= 1'b0;
            r_illegal   <= 1'b0;
            r_first_err <= '0;
        end else begin
            r_expected <= w_next;
            r_mismatch <= w_mismatch;
            r_illegal  <= w_illegal;
            if (w_mismatch && (w_err_count == '0))
                r_first_err <= count;

            case (r_state)
                UNLOCK: begin
                    if (w_resync)
                        r_state <= TRACK;
                end
                TRACK: begin
                    if (w_mismatch) begin
`ifdef CHECKER_STICKY_FAULT_EN
                        r_state <= FAULT;
`else
                        r_state <= w_resync ? TRACK : UNLOCK;
`endif
                    end
                end
                FAULT: begin
`ifdef CHECKER_STICKY_FAULT_EN
                    r_state <= FAULT;
`else
                    r_state <= UNLOCK;
`endif
                end
                default: r_state <= UNLOCK;
            endcase
        end
    end

    sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .clr   (reset),
        .inc   (w_mismatch),
        .value (w_err_count)
    );

    assign locked       = (r_state == TRACK);
    assign expected     = r_expected;
    assign mismatch     = r_mismatch;
    assign illegal_load = r_illegal;
    assign err_count    = w_err_count;
    assign first_err    = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_count_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_n_count_checker
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a cycle-level behavioural model of the checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_count_checker;

    localparam int c_width = 4;
    localparam int c_mod_n = 10;
    localparam int c_err_w = 8;
    localparam int c_err_max = (1 << c_err_w) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               dut_reset_n;
    logic               load;
    logic [c_width-1:0] load_data;
    logic [c_width-1:0] count;
    logic               locked;
    logic [c_width-1:0] expected;
    logic               mismatch;
    logic               illegal_load;
    logic [c_err_w-1:0] err_count;
    logic [c_width-1:0] first_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (values visible after the next clock edge)
    bit m_locked, m_fault, m_mismatch, m_illegal;
    int m_expected, m_err, m_first;
    // Behaviour of a correct counter, used to generate stimulus
    int ctr;

    mod_n_count_checker #(
        .WIDTH (c_width),
        .MOD_N (c_mod_n),
        .ERR_W (c_err_w)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dut_reset_n  (dut_reset_n),
        .load         (load),
        .load_data    (load_data),
        .count        (count),
        .locked       (locked),
        .expected     (expected),
        .mismatch     (mismatch),
        .illegal_load (illegal_load),
        .err_count    (err_count),
        .first_err    (first_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rn, input bit ld, input int ldd, input int c);
        bit bad;
        int ref_val;
        if (r) begin
            m_locked = 0; m_fault = 0; m_mismatch = 0; m_illegal = 0;
            m_expected = 0; m_err = 0; m_first = 0;
        end else begin
            ref_val = rn ? m_expected : 0;
            bad = m_locked && (c != ref_val);
            if (bad && m_err == 0) m_first = c;
            if (bad && m_err < c_err_max) m_err++;
            if (m_fault) begin
                m_locked = 0;
            end else if (m_locked) begin
                if (bad) begin
`ifdef CHECKER_STICKY_FAULT_EN
                    m_fault = 1; m_locked = 0;
`else
                    m_locked = !rn || ld;
`endif
                end
            end else begin
                m_locked = !rn || ld;
            end
            m_mismatch = bad;
            m_illegal  = ld && rn && (ldd >= c_mod_n);
            if (!rn) m_expected = 0;
            else if (ld) m_expected = ldd;
            else if (c >= c_mod_n - 1) m_expected = 0;
            else m_expected = c + 1;
        end
    endtask

    // One clock: apply inputs, advance model and stimulus counter, compare at negedge.
    task automatic drive(input bit r, input bit rn, input bit ld, input int ldd, input int c);
        reset = r; dut_reset_n = rn; load = ld;
        load_data = c_width'(ldd); count = c_width'(c);
        model_step(r, rn, ld, ldd, c);
        if (!rn) ctr = 0;
        else if (ld) ctr = ldd;
        else if (ctr >= c_mod_n - 1) ctr = 0;
        else ctr = ctr + 1;
        @(negedge clk);
        check("locked",       32'(locked),       32'(m_locked));
        check("expected",     32'(expected),     m_expected);
        check("mismatch",     32'(mismatch),     32'(m_mismatch));
        check("illegal_load", 32'(illegal_load), 32'(m_illegal));
        check("err_count",    32'(err_count),    m_err);
        check("first_err",    32'(first_err),    m_first);
    endtask

    task automatic tick();
        drive(0, 1, 0, 0, ctr);
    endtask

    initial begin
        ctr = 0;
        // Checker reset with the DUT held in reset
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rst_locked", 32'(locked), 0);
        drive(0, 0, 0, 0, 0);
        check("lock_after_dut_reset", 32'(locked), 1);
        // Free-run across the wrap
        for (int i = 0; i < 13; i++) tick();
        // Load 7 while locked, then keep counting
        drive(0, 1, 1, 7, ctr);
        tick();
        check("after_load7_expect8", 32'(expected), 8);
        // Steer to expected=3, then present 5
        drive(0, 1, 1, 2, ctr);
        tick();
        drive(0, 1, 0, 0, 5);
        check("inject_err_count", 32'(err_count), 1);
        check("inject_first_err", 32'(first_err), 5);
        check("inject_mismatch",  32'(mismatch), 1);
        check("inject_unlocked",  32'(locked), 0);
        tick();
        check("mismatch_one_cycle", 32'(mismatch), 0);
        // Illegal load value
        drive(0, 1, 1, 12, ctr);
        check("illegal_pulse", 32'(illegal_load), 1);
        check("illegal_raw_expected", 32'(expected), 12);
        tick();
        check("illegal_wrap", 32'(expected), 0);
        for (int i = 0; i < 3; i++) tick();
        // DUT reset plus illegal load together
        drive(0, 0, 1, 12, 0);
        check("rst_load_no_illegal", 32'(illegal_load), 0);
        check("rst_load_expected",   32'(expected), 0);
        for (int i = 0; i < 4; i++) tick();
        // Checker reset mid-operation
        drive(1, 1, 0, 0, ctr);
        check("midrst_err", 32'(err_count), 0);
        check("midrst_locked", 32'(locked), 0);
        // Saturation: keep resyncing with load while presenting a wrong count
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) drive(0, 1, 1, 0, 5);
`ifndef CHECKER_STICKY_FAULT_EN
        check("err_saturated", 32'(err_count), c_err_max);
`endif
        drive(1, 1, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            int c;
            sel = int'($urandom_range(0, 99));
            if (sel == 0) begin
                drive(1, 1, 0, 0, ctr);
            end else if (sel < 6) begin
                c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 0;
                drive(0, 0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), c);
            end else begin
                c = ctr;
                if ($urandom_range(0, 14) == 0) c = int'($urandom_range(0, 15));
                drive(0, 1, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), c);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
